pwm_fade_sequencer: RTL

PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

---
 rtl/pwm_fade_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: drives a PWM duty word through a fade. The duty ramps
// up one step per tick to the latched target, holds at the peak for hold_len+1
// cycles, then ramps down one step per tick back to zero.
// Ports: clk/rst (async active-high); start/stop requests; target, step_div and
//   hold_len are sampled when start is accepted; duty/duty_valid feed the PWM
//   datapath; busy is high outside IDLE; done pulses when a sequence ends.
// Optional macro FADE_LOOP_EN: when defined, the fade repeats until a stop has
//   been seen, and only then returns to IDLE with done.
module pwm_fade_sequencer #(
  parameter int DUTY_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DUTY_W-1:0] target,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [DIV_W-1:0]  hold_len,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DOWN = 2'd3;

  localparam logic [DUTY_W-1:0] DUTY_ONE = DUTY_W'(1);
  localparam logic [DIV_W-1:0]  CNT_ONE  = DIV_W'(1);

  logic [1:0]        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  // One counter serves as the step-tick divider in UP/DOWN and as the
  // peak-hold counter in HOLD; it is cleared on every state change.
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DIV_W-1:0]  step_q, step_d;
  logic [DIV_W-1:0]  hold_q, hold_d;
`ifdef FADE_LOOP_EN
  // Remembers any stop seen since start so the loop ends at the next zero.
  logic              stop_seen_q, stop_seen_d;
`endif

  logic tick;
  assign tick = (cnt_q == step_q);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    target_d = target_q;
    step_d   = step_q;
    hold_d   = hold_q;
`ifdef FADE_LOOP_EN
    stop_seen_d = stop_seen_q;
`endif
    case (state_q)
      S_IDLE: begin
        // stop is deliberately not looked at here, so start always wins.
        if (start) begin
          target_d = target;
          step_d   = step_div;
          hold_d   = hold_len;
          cnt_d    = '0;
          state_d  = S_UP;
`ifdef FADE_LOOP_EN
          stop_seen_d = 1'b0;
`endif
        end
      end
      S_UP: begin
        if (stop) begin
          state_d = S_DOWN;
          cnt_d   = '0;
`ifdef FADE_LOOP_EN
          stop_seen_d = 1'b1;
`endif
        end else if (duty_q == target_q) begin
          // Peak test precedes the increment, so duty can never pass target.
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (tick) begin
          duty_d  = duty_q + DUTY_ONE;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (stop || (cnt_q == hold_q)) begin
          state_d = S_DOWN;
          cnt_d   = '0;
`ifdef FADE_LOOP_EN
          if (stop) stop_seen_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DOWN: begin
`ifdef FADE_LOOP_EN
        if (stop) stop_seen_d = 1'b1;
`endif
        if (duty_q == '0) begin
`ifdef FADE_LOOP_EN
          if (stop_seen_q || stop) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_UP;
          end
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
          cnt_d = '0;
        end else if (tick) begin
          duty_d  = duty_q - DUTY_ONE;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      hold_q   <= '0;
`ifdef FADE_LOOP_EN
      stop_seen_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
`ifdef FADE_LOOP_EN
      stop_seen_q <= stop_seen_d;
`endif
    end
  end

  assign duty       = duty_q;
  assign duty_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule
